// File: rtl/timer_pkg.sv
// Shared types and default parameters for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } timer_state_t;

    localparam int TIMER_W_DEFAULT   = 8;
    localparam int TIMER_DIV_DEFAULT = 1;

endpackage

// File: rtl/prescaler.sv
// Modulo-DIV counter producing a one-cycle tick every DIV enabled cycles.
module prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic enb,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};

    logic [CW-1:0] cnt_r;

    // Prescale counter: cleared on request, advances only while enabled, wraps at DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO;
        end else if (clr) begin
            cnt_r <= ZERO;
        end else if (enb) begin
            if (cnt_r == LAST) begin
                cnt_r <= ZERO;
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = enb && (cnt_r == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counter with prescaler, start/stop/hold control,
// terminal-count pulse and optional auto-reload.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int W   = TIMER_W_DEFAULT,
    parameter int DIV = TIMER_DIV_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         auto_reload,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         tc
);

    localparam logic [W-1:0] Q_ZERO = {W{1'b0}};
    localparam logic [W-1:0] Q_ONE  = W'(1'b1);

    timer_state_t state_r;
    timer_state_t state_next;
    logic [W-1:0] q_r;
    logic [W-1:0] q_next;
    logic [W-1:0] reload_r;
    logic         tc_r;
    logic         tc_next;
    logic         busy_r;
    logic         clr_s;
    logic         enb_s;
    logic         tick_s;

    // The prescaler freezes on a stop edge so that a pause costs exactly its own cycles.
    assign enb_s = (state_r == RUN) && !stop && !load;
    assign clr_s = load || ((state_r == IDLE) && start);

    prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .enb (enb_s),
        .tick(tick_s)
    );

    // Next-state and count logic, priority load > stop > start > tick
    always_comb begin
        state_next = state_r;
        q_next     = q_r;
        tc_next    = 1'b0;
        if (load) begin
            q_next     = load_val;
            state_next = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !stop && (q_r != Q_ZERO)) begin
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = HOLD;
                    end else if (tick_s) begin
                        if (q_r > Q_ONE) begin
                            q_next = q_r - Q_ONE;
                        end else if (q_r == Q_ONE) begin
                            tc_next = 1'b1;
                            if (auto_reload) begin
                                q_next = reload_r;
                            end else begin
                                q_next     = Q_ZERO;
                                state_next = IDLE;
                            end
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = RUN;
                    end
                end
                HOLD: begin
                    if (start && !stop) begin
                        state_next = RUN;
                    end else begin
                        state_next = HOLD;
                    end
                end
                default: begin
                    state_next = IDLE;
                    q_next     = Q_ZERO;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Count, reload value and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r      <= Q_ZERO;
            reload_r <= Q_ZERO;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            q_r      <= q_next;
            reload_r <= load ? load_val : reload_r;
            tc_r     <= tc_next;
            busy_r   <= (state_next != IDLE);
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: DIV=1 and DIV=4 instances on shared inputs,
// checked every cycle against an elapsed-time model plus directed literals.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [7:0] q1, q4;
    logic       busy1, busy4, tc1, tc4;

    int n_checks = 0;
    int n_fail = 0;

    countdown_timer #(.W(8), .DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .auto_reload(auto_reload), .q(q1), .busy(busy1), .tc(tc1)
    );

    countdown_timer #(.W(8), .DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .auto_reload(auto_reload), .q(q4), .busy(busy4), .tc(tc4)
    );

    always #5 clk = ~clk;

    // Model: q = N - floor(run_cycles_elapsed / DIV); terminal when elapsed reaches N*DIV.
    int m_div[2] = '{1, 4};
    int m_n[2]   = '{0, 0};
    int m_e[2]   = '{0, 0};
    bit m_act[2] = '{1'b0, 1'b0};
    bit m_pause[2] = '{1'b0, 1'b0};
    bit m_tc[2]  = '{1'b0, 1'b0};

    function automatic int model_q(input int k);
        return m_n[k] - (m_e[k] / m_div[k]);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_n[k] = 0; m_e[k] = 0; m_act[k] = 1'b0; m_pause[k] = 1'b0; m_tc[k] = 1'b0;
                end else if (load) begin
                    m_n[k] = int'(load_val); m_e[k] = 0; m_act[k] = 1'b0; m_pause[k] = 1'b0; m_tc[k] = 1'b0;
                end else if (!m_act[k]) begin
                    m_tc[k] = 1'b0;
                    if (start && !stop && model_q(k) != 0) begin
                        m_act[k] = 1'b1;
                        m_e[k] = (m_e[k] / m_div[k]) * m_div[k];
                    end
                end else if (m_pause[k]) begin
                    m_tc[k] = 1'b0;
                    if (start && !stop) m_pause[k] = 1'b0;
                end else if (stop) begin
                    m_tc[k] = 1'b0;
                    m_pause[k] = 1'b1;
                end else begin
                    m_e[k] = m_e[k] + 1;
                    m_tc[k] = 1'b0;
                    if (m_e[k] == m_n[k] * m_div[k]) begin
                        m_tc[k] = 1'b1;
                        if (auto_reload) m_e[k] = 0;
                        else m_act[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("q_d1", int'(q1), model_q(0));
            check("busy_d1", int'(busy1), int'(m_act[0]));
            check("tc_d1", int'(tc1), int'(m_tc[0]));
            check("q_d4", int'(q4), model_q(1));
            check("busy_d4", int'(busy4), int'(m_act[1]));
            check("tc_d4", int'(tc4), int'(m_tc[1]));
        end
    end

    // Apply inputs for one edge; returns at the following negedge
    task automatic step(input logic l, input logic [7:0] v, input logic s, input logic p);
        load = l; load_val = v; start = s; stop = p;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_q", int'(q1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_tc", int'(tc1), 0);
        rst = 1'b0;

        // start with q = 0 is ignored
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("zero_start_busy", int'(busy1), 0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("zero_start_tc", int'(tc1), 0);

        // basic countdown, DIV=1
        step(1'b1, 8'd5, 1'b0, 1'b0);
        check("basic_load_q", int'(q1), 5);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("basic_busy_rise", int'(busy1), 1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            check("basic_q", int'(q1), 5 - i);
        end
        check("basic_tc", int'(tc1), 1);
        check("basic_busy_fall", int'(busy1), 0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("basic_tc_width", int'(tc1), 0);
        repeat (20) step(1'b0, 8'd0, 1'b0, 1'b0);

        // prescale, DIV=4
        step(1'b1, 8'd3, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("pre_q0", int'(q4), 3);
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            check("pre_q", int'(q4), 3 - i / 4);
            check("pre_tc", int'(tc4), (i == 12) ? 1 : 0);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("pre_busy_end", int'(busy4), 0);

        // pause / resume, with start+stop together while held
        step(1'b1, 8'd10, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'd0, 1'b0, 1'b0);
        check("pause_q_before", int'(q1), 7);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("pause_q_stop", int'(q1), 7);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b1);
        check("hold_start_stop_busy", int'(busy1), 1);
        check("hold_start_stop_q", int'(q1), 7);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("hold_q", int'(q1), 7);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("resume_q", int'(q1), 7);
        for (int j = 10; j <= 16; j++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            check("resume_cnt", int'(q1), 16 - j);
        end
        check("pause_tc", int'(tc1), 1);

        // auto-reload period 3
        auto_reload = 1'b1;
        step(1'b1, 8'd3, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b0);
            check("auto_q", int'(q1), (i % 3 == 0) ? 3 : 3 - (i % 3));
            check("auto_tc", int'(tc1), (i % 3 == 0) ? 1 : 0);
            check("auto_busy", int'(busy1), 1);
        end
        auto_reload = 1'b0;

        // load with simultaneous start while running
        step(1'b1, 8'd5, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 8'd9, 1'b1, 1'b0);
        check("load_run_q", int'(q1), 9);
        check("load_run_busy", int'(busy1), 0);

        // asynchronous reset mid-count
        step(1'b1, 8'd10, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 8'd0, 1'b0, 1'b0);
        check("arst_pre_q", int'(q1), 4);
        #2 rst = 1'b1;
        #1;
        check("arst_q", int'(q1), 0);
        check("arst_busy", int'(busy1), 0);
        check("arst_tc", int'(tc1), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'd0, 1'b1, 1'b0);
        check("arst_start_busy", int'(busy1), 0);

        // randomized traffic
        repeat (3000) begin
            auto_reload = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 24) == 0), 8'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        step(1'b0, 8'd0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
